// File: rtl/irrig_ctrl.sv
// rtl/irrig_ctrl.sv - irrigation plant sequencer; define IRRIG_COOLDOWN_EN to add the PAUSE state
module irrig_ctrl #(
  parameter int CNT_W   = 8,
  parameter int MIN_ON  = 16,
  parameter int FILL_TO = 200,
  parameter int COOL    = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       l,
  input  logic       m,
  input  logic       h,
  input  logic       sd,
  input  logic       su,
  input  logic       clr,
  output logic       ve,
  output logic       vs,
  output logic       bs,
  output logic       al,
  output logic [2:0] st
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    SPRK  = 3'd2,
    DRIP  = 3'd3,
    ERR   = 3'd4
`ifdef IRRIG_COOLDOWN_EN
    , PAUSE = 3'd5
`endif
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] MIN_LAST  = CNT_W'(MIN_ON - 1);
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_TO - 1);
`ifdef IRRIG_COOLDOWN_EN
  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOL - 1);
  localparam state_t           DONE      = PAUSE;
`else
  localparam state_t           DONE      = IDLE;
`endif

  // All three timers share one counter, so each must fit in it.
  if (CNT_W < 1 || MIN_ON < 1 || FILL_TO < 1 || COOL < 1 ||
      MIN_ON > (1 << CNT_W) - 1 || FILL_TO > (1 << CNT_W) - 1 ||
      COOL > (1 << CNT_W) - 1) begin : g_bad_params
    $error("irrig_ctrl: MIN_ON, FILL_TO and COOL must lie in 1..2^CNT_W-1");
  end

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic             levels_ok;

  // Sensors are stacked, so a higher one wet with a lower one dry is a fault.
  assign levels_ok = ({h, m, l} == 3'b000) || ({h, m, l} == 3'b001) ||
                     ({h, m, l} == 3'b011) || ({h, m, l} == 3'b111);

  always_comb begin
    nxt = state;
    if (!levels_ok) begin
      nxt = ERR;
    end else if (state == ERR) begin
      if (clr) nxt = IDLE;
    end else if (!en) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!l)            nxt = FILL;
          else if (su && m)  nxt = SPRK;
          else if (su || sd) nxt = DRIP;
          else if (!h)       nxt = FILL;
        end
        FILL: begin
          if (h)                     nxt = IDLE;
          else if (cnt == FILL_LAST) nxt = ERR;
        end
        SPRK: begin
          if (!l)                                nxt = IDLE;
          else if (cnt >= MIN_LAST && (!su || !m)) nxt = DONE;
        end
        DRIP: begin
          if (!l)                                nxt = IDLE;
          else if (cnt >= MIN_LAST && !sd && !su) nxt = DONE;
        end
`ifdef IRRIG_COOLDOWN_EN
        PAUSE: begin
          if (cnt == COOL_LAST) nxt = IDLE;
        end
`endif
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ve    <= 1'b0;
      vs    <= 1'b0;
      bs    <= 1'b0;
      al    <= 1'b0;
      st    <= 3'd0;
    end else begin
      state <= nxt;
      if (nxt != state)      cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      ve <= (nxt == FILL);
      vs <= (nxt == SPRK);
      bs <= (nxt == DRIP);
      al <= (nxt == ERR);
      st <= nxt;
    end
  end

endmodule

// File: tb/tb_irrig_ctrl.sv
// tb/tb_irrig_ctrl.sv - self-checking bench for irrig_ctrl against a rule-level model
module tb_irrig_ctrl;
  localparam int MIN_ON  = 16;
  localparam int FILL_TO = 200;
  localparam int COOL    = 32;

  logic clk = 1'b0;
  logic rst, en, l, m, h, sd, su, clr;
  logic ve, vs, bs, al;
  logic [2:0] st;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;
  int m_st = 0;
  int m_age = 0;
  int n;

  always #5 clk = ~clk;

  irrig_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .l(l), .m(m), .h(h), .sd(sd), .su(su),
    .clr(clr), .ve(ve), .vs(vs), .bs(bs), .al(al), .st(st)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Next state code from the written rules; age = whole cycles already spent in s.
  function automatic int mnext(input int s, input int age, input bit e, input bit hh,
                               input bit mm, input bit ll, input bit dry, input bit vdry,
                               input bit ack);
    int done;
`ifdef IRRIG_COOLDOWN_EN
    done = 5;
`else
    done = 0;
`endif
    if (!({hh, mm, ll} inside {3'b000, 3'b001, 3'b011, 3'b111})) return 4;
    if (s == 4) return ack ? 0 : 4;
    if (!e) return 0;
    case (s)
      0: begin
        if (!ll) return 1;
        if (vdry && mm) return 2;
        if (vdry || dry) return 3;
        if (!hh) return 1;
        return 0;
      end
      1: begin
        if (hh) return 0;
        if (age == FILL_TO - 1) return 4;
        return 1;
      end
      2: begin
        if (!ll) return 0;
        if (age >= MIN_ON - 1 && (!vdry || !mm)) return done;
        return 2;
      end
      3: begin
        if (!ll) return 0;
        if (age >= MIN_ON - 1 && !dry && !vdry) return done;
        return 3;
      end
      5: return (age == COOL - 1) ? 0 : 5;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_st  <= 0;
      m_age <= 0;
    end else begin
      automatic int nx = mnext(m_st, m_age, en, h, m, l, sd, su, clr);
      m_st  <= nx;
      m_age <= (nx != m_st) ? 0 : m_age + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("st", int'(st), m_st);
      chk("ve", int'(ve), int'(m_st == 1));
      chk("vs", int'(vs), int'(m_st == 2));
      chk("bs", int'(bs), int'(m_st == 3));
      chk("al", int'(al), int'(m_st == 4));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_in(input bit e, input bit hh, input bit mm, input bit ll,
                        input bit dry, input bit vdry, input bit ack);
    en = e; h = hh; m = mm; l = ll; sd = dry; su = vdry; clr = ack;
  endtask

  task automatic count_state(input int code, output int cnt_out);
    cnt_out = 0;
    while (int'(st) == code && cnt_out < 400) begin
      cnt_out++;
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set_in(1, 1, 1, 1, 1, 1, 1);
    tick();
    tick();
    chk_on = 1'b1;
    chk("rst_st", int'(st), 0);
    chk("rst_valves", int'({ve, vs, bs, al}), 0);

    rst = 1'b0;
    set_in(1, 1, 1, 1, 0, 0, 0);
    repeat (20) tick();
    chk("idle_full", int'(st), 0);

    set_in(1, 0, 0, 0, 0, 0, 0);
    tick();
    chk("fill_entry_st", int'(st), 1);
    chk("fill_entry_ve", int'(ve), 1);
    set_in(1, 0, 0, 1, 0, 0, 0);
    repeat (10) tick();
    set_in(1, 0, 1, 1, 0, 0, 0);
    repeat (10) tick();
    set_in(1, 1, 1, 1, 0, 0, 0);
    tick();
    chk("fill_full_st", int'(st), 0);
    chk("fill_full_ve", int'(ve), 0);

    set_in(1, 0, 0, 1, 0, 0, 0);
    tick();
    chk("fill2_entry", int'(st), 1);
    count_state(1, n);
    chk("fill_timeout_len", n, FILL_TO);
    chk("timeout_al", int'(al), 1);
    clr = 1'b1;
    tick();
    chk("clr_idle", int'(st), 0);
    clr = 1'b0;
    tick();
    chk("refill", int'(st), 1);

    set_in(1, 1, 1, 1, 0, 1, 0);
    tick();
    chk("fill_to_idle", int'(st), 0);
    tick();
    chk("sprk_entry", int'(st), 2);
    chk("sprk_vs", int'(vs), 1);
    repeat (3) tick();
    su = 1'b0;
    count_state(2, n);
    chk("sprk_min_on", n + 3, MIN_ON);
`ifdef IRRIG_COOLDOWN_EN
    chk("pause_entry", int'(st), 5);
    count_state(5, n);
    chk("pause_len", n, COOL);
`endif
    chk("sprk_exit", int'(st), 0);

    set_in(1, 0, 0, 1, 1, 0, 0);
    tick();
    chk("drip_entry", int'(st), 3);
    chk("drip_bs", int'(bs), 1);
    repeat (4) tick();
    l = 1'b0;
    tick();
    chk("drip_protect_st", int'(st), 0);
    chk("drip_protect_bs", int'(bs), 0);
    tick();
    chk("empty_refill", int'(st), 1);

    set_in(1, 1, 1, 1, 0, 1, 0);
    tick();
    tick();
    chk("sprk2_entry", int'(st), 2);
    set_in(1, 1, 0, 1, 0, 1, 0);
    tick();
    chk("bad_lvl_st", int'(st), 4);
    chk("bad_lvl_vs", int'(vs), 0);
    chk("bad_lvl_al", int'(al), 1);
    clr = 1'b1;
    tick();
    chk("clr_ignored", int'(st), 4);
    rst = 1'b1;
    tick();
    chk("rst_in_err", int'(st), 0);
    rst = 1'b0;
    clr = 1'b0;

    for (int cyc = 0; cyc < 3000; ) begin
      int r;
      int hold;
      logic [2:0] lv;
      r = $urandom_range(0, 99);
      if (r < 4) lv = 3'b010 + 3'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(2, 4));
      else case ($urandom_range(0, 3))
        0: lv = 3'b000;
        1: lv = 3'b001;
        2: lv = 3'b011;
        default: lv = 3'b111;
      endcase
      set_in($urandom_range(0, 99) < 95, lv[2], lv[1], lv[0],
             $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
             $urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 199) == 0);
      hold = ($urandom_range(0, 9) == 0) ? $urandom_range(20, 220) : $urandom_range(1, 8);
      repeat (hold) tick();
      rst = 1'b0;
      cyc += hold;
    end

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
